dadder_bcd_core: RTL and testbench

- Digit-serial decimal (BCD) adder/subtracter core.
- This is the DUT that the dadder bench checker binds to.
- Accepts two unsigned NUM_DIGITS-digit BCD operands and an add/sub opcode on a valid/ready input port.
- Computes one digit per cycle, then presents a sign-magnitude BCD result with overflow on a valid/ready output port.
- A control-plane enable gates new work.

---
 rtl/dadder_bcd_core.sv | 170 +++++++++++++++++
 tb/tb_dadder_bcd_core.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dadder_bcd_core.sv
// Digit-serial BCD add/sub core giving a sign-magnitude result (optional DADDER_INVALID_DIGIT_CHK_EN).
// Latency NUM_DIGITS+1 cycles, 2*NUM_DIGITS+1 for a negative difference; operations never overlap.
// Backpressure: result held in DONE until out_ready; in_ready stays low while an op is in flight.
module dadder_bcd_core #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_op,
  input  logic [4*NUM_DIGITS-1:0] in_a,
  input  logic [4*NUM_DIGITS-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_result,
  output logic                    out_sign,
  output logic                    out_overflow,
  output logic                    out_err
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q, r_q, res_q, new_r;
  logic           op_q, c_q, sign_q, ovf_q, run_q;
  logic [IW-1:0]  idx_q;
  logic [3:0]     op_x, op_y, dig;
  logic [4:0]     sum;
  logic           carry, last, accept, err_now;

  // run_q keeps in_ready low while reset is asserted and for the first cycle after release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  assign in_ready     = (state_q == IDLE) && en && run_q;
  assign accept       = in_valid && in_ready;
  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_result   = res_q;
  assign out_sign     = sign_q;
  assign out_overflow = ovf_q;
  assign last         = (idx_q == IW'(NUM_DIGITS - 1));

`ifdef DADDER_INVALID_DIGIT_CHK_EN
  logic in_bad, err_q;

  always_comb begin
    in_bad = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (in_a[4*k +: 4] > 4'd9 || in_b[4*k +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    err_q <= 1'b0;
    else if (accept) err_q <= in_bad;
  end

  assign err_now = err_q;
  assign out_err = err_q;
`else
  assign err_now = 1'b0;
  assign out_err = 1'b0;
`endif

  // One shared digit adder: CALC adds A and (9's complemented) B, NEG re-complements R
  always_comb begin
    op_x = a_q[3:0];
    op_y = op_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    if (state_q == NEG) begin
      op_x = 4'd9 - r_q[3:0];
      op_y = 4'd0;
    end
    sum   = {1'b0, op_x} + {1'b0, op_y} + {4'd0, c_q};
    carry = (sum > 5'd9);
    dig   = carry ? 4'(sum - 5'd10) : sum[3:0];
    new_r = (r_q >> 4) | (W'(dig) << (W - 4));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        if (err_now)                  state_d = DONE;
        else if (last && (!op_q || carry)) state_d = DONE;
        else if (last)                state_d = NEG;
      end
      NEG:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      res_q  <= '0;
      op_q   <= 1'b0;
      c_q    <= 1'b0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= in_op;
            c_q   <= in_op;
            idx_q <= '0;
            r_q   <= '0;
          end
        end
        CALC: begin
          if (err_now) begin
            res_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
          end else begin
            a_q   <= a_q >> 4;
            b_q   <= b_q >> 4;
            r_q   <= new_r;
            c_q   <= carry;
            idx_q <= idx_q + IW'(1);
            if (last) begin
              if (!op_q || carry) begin
                res_q  <= new_r;
                sign_q <= 1'b0;
                ovf_q  <= !op_q && carry;
              end else begin
                // A<B: R is the ten's complement, convert back to a magnitude
                idx_q <= '0;
                c_q   <= 1'b1;
              end
            end
          end
        end
        NEG: begin
          r_q   <= new_r;
          c_q   <= carry;
          idx_q <= idx_q + IW'(1);
          if (last) begin
            res_q  <= new_r;
            sign_q <= 1'b1;
            ovf_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dadder_bcd_core.sv
// Scoreboard bench for dadder_bcd_core: integer reference model, queued expectations, decoupled monitor.
module tb_dadder_bcd_core;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b1;
  logic         busy;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_op = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_sign;
  logic         out_overflow;
  logic         out_err;

  logic ready_man = 1'b1;
  logic bp_mode   = 1'b0;
  logic bp_bit    = 1'b1;
  assign out_ready = bp_mode ? bp_bit : ready_man;

  typedef struct {
    logic [W-1:0] res;
    logic         sign;
    logic         ovf;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  dadder_bcd_core #(.NUM_DIGITS(N)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_sign(out_sign), .out_overflow(out_overflow), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) bp_bit = ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int k = N - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int k = 0; k < N; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ia = bcd2int(a);
    int ib = bcd2int(b);
    int lim = 10 ** N;
    e.err = 1'b0; e.sign = 1'b0; e.ovf = 1'b0; e.acc = 0;
    if (!op) begin
      e.res = int2bcd((ia + ib) % lim);
      e.ovf = (ia + ib) >= lim;
      e.lat = N + 1;
    end else if (ia >= ib) begin
      e.res = int2bcd(ia - ib);
      e.lat = N + 1;
    end else begin
      e.res  = int2bcd(ib - ia);
      e.sign = 1'b1;
      e.lat  = 2 * N + 1;
    end
`ifdef DADDER_INVALID_DIGIT_CHK_EN
    for (int k = 0; k < N; k++) begin
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) e.err = 1'b1;
    end
    if (e.err) begin
      e.res = '0; e.sign = 1'b0; e.ovf = 1'b0; e.lat = 2;
    end
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the accept
  task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    exp_t e;
    int t = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      acc = -1;
    end else begin
      acc = cyc;
      e = model(op, a, b);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || busy) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  // Monitor: samples 1 time unit after the negedge, when all drivers have settled
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        check("valid_ready_excl", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!prev_valid) check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
          check("result",   {16'd0, out_result},   {16'd0, exp_q[0].res});
          check("sign",     {31'd0, out_sign},     {31'd0, exp_q[0].sign});
          check("overflow", {31'd0, out_overflow}, {31'd0, exp_q[0].ovf});
          check("err",      {31'd0, out_err},      {31'd0, exp_q[0].err});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    int acc, h, t;
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},     32'd0);
    check("rst_out_valid", {31'd0, out_valid},    32'd0);
    check("rst_busy",      {31'd0, busy},         32'd0);
    check("rst_result",    {16'd0, out_result},   32'd0);
    check("rst_sign",      {31'd0, out_sign},     32'd0);
    check("rst_overflow",  {31'd0, out_overflow}, 32'd0);
    check("rst_err",       {31'd0, out_err},      32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    send(1'b0, 16'h1234, 16'h5678, acc); wait_drain(100);
    send(1'b0, 16'h9999, 16'h0001, acc); wait_drain(100);
    send(1'b0, 16'h9999, 16'h9999, acc); wait_drain(100);
    send(1'b1, 16'h0100, 16'h0250, acc); wait_drain(100);
    send(1'b1, 16'h0500, 16'h0500, acc); wait_drain(100);
    send(1'b1, 16'h0000, 16'h9999, acc); wait_drain(100);

    // Backpressure: hold result for 10 cycles, then a queued beat is taken one cycle after release
    ready_man = 1'b0;
    send(1'b1, 16'h7000, 16'h0123, acc);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
    end
    ready_man = 1'b1;
    h = cyc;
    send(1'b0, 16'h0042, 16'h0058, acc);
    check("bp_next_accept", acc - h, 32'd1);
    wait_drain(100);

    // en=0 blocks acceptance
    en = 1'b0;
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_op = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("en0_in_ready", {31'd0, in_ready}, 32'd0);
    end
    check("en0_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    en = 1'b1;
    @(negedge clk);

    // en dropped mid-CALC: the operation still completes
    send(1'b1, 16'h0300, 16'h0450, acc);
    en = 1'b0;
    wait_drain(100);
    en = 1'b1;
    @(negedge clk);

    // Reset mid-CALC discards the op and clears every output at once
    send(1'b0, 16'h4321, 16'h1111, acc);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_in_ready",  {31'd0, in_ready},     32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid},    32'd0);
    check("mid_rst_busy",      {31'd0, busy},         32'd0);
    check("mid_rst_result",    {16'd0, out_result},   32'd0);
    check("mid_rst_sign",      {31'd0, out_sign},     32'd0);
    check("mid_rst_overflow",  {31'd0, out_overflow}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef DADDER_INVALID_DIGIT_CHK_EN
    send(1'b0, 16'h12A4, 16'h0001, acc); wait_drain(100);
    send(1'b0, 16'h0012, 16'h0034, acc); wait_drain(100);
`endif

    // Randomized traffic with random backpressure
    bp_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), rand_bcd(), rand_bcd(), acc);
    end
    wait_drain(1000);
    bp_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
